// File: rtl/pakout_arb_pkg.sv
// Shared sizing defaults, output FSM encoding and width helpers for pakout_arb.
package pakout_arb_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 6;
  localparam int NS_REDUN_SIZE   = 2;
  localparam int NS_PACKET_SIZE  = 4;
  localparam int NS_REQ_CKS      = 3;
  localparam int NS_ACK_CKS      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_REL  = 2'd2
  } snd_st_e;

  function automatic int pakarb_msz(input int asz, input int dsz, input int rsz);
    return asz + dsz + rsz;
  endfunction

  function automatic int pakarb_tot_pks(input int msz, input int psz);
    return (msz + psz - 1) / psz;
  endfunction

  function automatic int pakarb_idx_w(input int tot);
    return (tot <= 1) ? 1 : $clog2(tot);
  endfunction

endpackage

// File: rtl/pakout_arb_if.sv
// Vectored message-in / packet-out handshake group of pakout_arb.
interface pakout_arb_if #(
  parameter int N_IN = 2,
  parameter int MSZ  = 14,
  parameter int PSZ  = 4,
  parameter int IW   = 2
);
  logic                      ready;
  logic [N_IN-1:0]           rcv_req;
  logic [N_IN-1:0]           rcv_ack;
  // channel i sits at bits [i*MSZ +: MSZ], fields {addr, data, redun}
  logic [N_IN-1:0][MSZ-1:0]  rcv_msg;
  logic                      snd_req;
  logic                      snd_ack;
  logic [PSZ-1:0]            snd_pakio;
  logic [IW-1:0]             snd_idx;

  modport master (
    output ready, rcv_ack, snd_req, snd_pakio, snd_idx,
    input  rcv_req, rcv_msg, snd_ack
  );

  modport slave (
    input  ready, rcv_ack, snd_req, snd_pakio, snd_idx,
    output rcv_req, rcv_msg, snd_ack
  );
endinterface

// File: rtl/pakout_arb_fifo.sv
// Message FIFO; pointers carry an extra wrap bit to tell full from empty.
module pakout_arb_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pakout_arb.sv
// N_IN-channel round-robin message arbiter feeding a shared FIFO that is
// serialised into TOT_PKS fixed-width packets on one four-phase link.
module pakout_arb
  import pakout_arb_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int ASZ     = NS_ADDRESS_SIZE,
  parameter int DSZ     = NS_DATA_SIZE,
  parameter int RSZ     = NS_REDUN_SIZE,
  parameter int PSZ     = NS_PACKET_SIZE,
  parameter int FSZ     = 4,
  parameter int REQ_CKS = NS_REQ_CKS,
  parameter int ACK_CKS = NS_ACK_CKS
) (
  input  logic          i_clk,
  input  logic          reset,
  pakout_arb_if.master  bus
);
  localparam int MSZ     = pakarb_msz(ASZ, DSZ, RSZ);
  localparam int TOT_PKS = pakarb_tot_pks(MSZ, PSZ);
  localparam int IW      = pakarb_idx_w(TOT_PKS);
  localparam int PADW    = TOT_PKS * PSZ;
  localparam int PW      = (N_IN <= 1) ? 1 : $clog2(N_IN);
  localparam int NDB     = N_IN + 1;

  // ---------------- debouncers: lanes 0..N_IN-1 are rcv_req, lane N_IN is snd_ack
  logic [NDB-1:0] db_raw, db_val, db_rdy;
  logic [N_IN-1:0] req_db;
  logic            ack_db;

  assign db_raw = {bus.snd_ack, bus.rcv_req};
  assign req_db = db_val[N_IN-1:0];
  assign ack_db = db_val[N_IN];

  for (genvar g = 0; g < NDB; g++) begin : g_db
    localparam int CKS = (g == N_IN) ? ACK_CKS : REQ_CKS;
    localparam int CW  = (CKS <= 1) ? 1 : $clog2(CKS);
    logic [CW-1:0] cnt;
    logic          val, rdy;

    // value flips only after the raw line has disagreed for CKS straight edges
    always_ff @(posedge i_clk) begin
      if (reset) begin
        cnt <= '0;
        val <= 1'b0;
        rdy <= 1'b0;
      end else begin
        rdy <= 1'b1;
        if (db_raw[g] == val) begin
          cnt <= '0;
        end else if (cnt == CW'(CKS - 1)) begin
          val <= db_raw[g];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign db_val[g] = val;
    assign db_rdy[g] = rdy;
  end

  // ---------------- init / ready
  logic init_q, ready;

  always_ff @(posedge i_clk) begin
    if (reset) init_q <= 1'b0;
    else       init_q <= 1'b1;
  end

  assign ready = init_q && (&db_rdy);

  // ---------------- round-robin arbiter
  logic [PW-1:0]   ptr, gnt_idx;
  logic            gnt_vld;
  logic [N_IN-1:0] ack_q, elig;
  logic            full, empty, pop;
  logic [MSZ-1:0]  head;

  assign elig = req_db & ~ack_q & {N_IN{ready && !full}};

  // walk from the farthest candidate back so the one nearest ptr wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % N_IN]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % N_IN);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      ptr   <= '0;
      ack_q <= '0;
    end else begin
      if (gnt_vld) ptr <= (gnt_idx == PW'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (gnt_vld && gnt_idx == PW'(i))    ack_q[i] <= 1'b1;
        else if (!req_db[i] && ack_q[i])     ack_q[i] <= 1'b0;
      end
    end
  end

  pakout_arb_fifo #(.W(MSZ), .DEPTH(FSZ)) u_fifo (
    .i_clk     (i_clk),
    .reset     (reset),
    .push      (gnt_vld),
    .push_data (bus.rcv_msg[gnt_idx]),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // ---------------- packet output FSM
  snd_st_e        st;
  logic [IW-1:0]  idx;
  logic           snd_req;
  logic [PSZ-1:0] pak;
  logic           last;

  // packet k is message bits [k*PSZ +: PSZ]; bits past MSZ read as zero
  function automatic logic [PSZ-1:0] slice(input logic [MSZ-1:0] m, input logic [IW-1:0] k);
    logic [PADW-1:0] p;
    p          = '0;
    p[MSZ-1:0] = m;
    return p[int'(k) * PSZ +: PSZ];
  endfunction

  assign last = (idx == IW'(TOT_PKS - 1));
  assign pop  = (st == ST_REL) && !ack_db && last;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      st      <= ST_IDLE;
      idx     <= '0;
      snd_req <= 1'b0;
      pak     <= '0;
    end else begin
      case (st)
        ST_IDLE: if (!empty) begin
          pak     <= slice(head, '0);
          idx     <= '0;
          snd_req <= 1'b1;
          st      <= ST_SEND;
        end
        ST_SEND: if (ack_db) begin
          snd_req <= 1'b0;
          st      <= ST_REL;
        end
        ST_REL: if (!ack_db) begin
          if (last) begin
            idx <= '0;
            st  <= ST_IDLE;
          end else begin
            idx     <= idx + 1'b1;
            pak     <= slice(head, idx + 1'b1);
            snd_req <= 1'b1;
            st      <= ST_SEND;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready;
  assign bus.rcv_ack   = ack_q;
  assign bus.snd_req   = snd_req;
  assign bus.snd_pakio = pak;
  assign bus.snd_idx   = idx;
endmodule

// File: tb/tb_pakout_arb.sv
// Scoreboard bench for pakout_arb: expected packets are queued as messages are
// offered and compared as the link side receives them.
module tb_pakout_arb;
  import pakout_arb_pkg::*;

  localparam int N_IN    = 2;
  localparam int PSZ     = NS_PACKET_SIZE;
  localparam int MSZ     = pakarb_msz(NS_ADDRESS_SIZE, NS_DATA_SIZE, NS_REDUN_SIZE);
  localparam int TOT_PKS = pakarb_tot_pks(MSZ, PSZ);
  localparam int IW      = pakarb_idx_w(TOT_PKS);
  localparam int FSZ     = 4;
  localparam int REQ_CKS = NS_REQ_CKS;
  localparam int ACK_CKS = NS_ACK_CKS;
  localparam int LIM     = 300;

  typedef struct {
    logic [PSZ-1:0] pak;
    logic [IW-1:0]  idx;
  } exp_t;

  logic i_clk = 1'b0;
  logic reset = 1'b1;
  always #5 i_clk = ~i_clk;

  pakout_arb_if #(.N_IN(N_IN), .MSZ(MSZ), .PSZ(PSZ), .IW(IW)) bus ();

  pakout_arb #(
    .N_IN(N_IN), .PSZ(PSZ), .FSZ(FSZ), .REQ_CKS(REQ_CKS), .ACK_CKS(ACK_CKS)
  ) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   pkts_rcvd = 0;
  int   ack_rise [N_IN];
  logic [N_IN-1:0] ack_prev = '0;

  initial for (int i = 0; i < N_IN; i++) ack_rise[i] = 0;

  always @(negedge i_clk) begin
    for (int i = 0; i < N_IN; i++)
      if (bus.rcv_ack[i] && !ack_prev[i]) ack_rise[i]++;
    ack_prev = bus.rcv_ack;
  end

  task automatic expect_msg(input logic [MSZ-1:0] m);
    logic [63:0] w;
    w = 64'(m);
    for (int k = 0; k < TOT_PKS; k++)
      exp_q.push_back('{pak: PSZ'(w >> (k * PSZ)), idx: IW'(k)});
  endtask

  task automatic send_msg(input int ch, input logic [MSZ-1:0] m);
    int t;
    bus.rcv_msg[ch] = m;
    bus.rcv_req[ch] = 1'b1;
    for (t = 0; t < LIM && !bus.rcv_ack[ch]; t++) @(negedge i_clk);
    if (!bus.rcv_ack[ch]) begin
      n_chk++;
      $display("FAIL send_ack_ch%0d: rcv_ack=%b required 1 within %0d cycles", ch, bus.rcv_ack[ch], LIM);
    end
    bus.rcv_req[ch] = 1'b0;
    for (t = 0; t < LIM && bus.rcv_ack[ch]; t++) @(negedge i_clk);
  endtask

  task automatic recv_pkts(input int n);
    int   t;
    exp_t e;
    for (int p = 0; p < n; p++) begin
      for (t = 0; t < LIM && !bus.snd_req; t++) @(negedge i_clk);
      n_chk++;
      if (!bus.snd_req) begin
        $display("FAIL recv_req: snd_req=0 required 1 within %0d cycles", LIM);
        return;
      end
      n_pass++;
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL recv_unexpected: packet %h idx %0d with empty scoreboard", bus.snd_pakio, bus.snd_idx);
      end else begin
        e = exp_q.pop_front();
        if (bus.snd_pakio !== e.pak || bus.snd_idx !== e.idx)
          $display("FAIL recv_pkt: got pak=%h idx=%0d required pak=%h idx=%0d",
                   bus.snd_pakio, bus.snd_idx, e.pak, e.idx);
        else n_pass++;
      end
      pkts_rcvd++;
      bus.snd_ack = 1'b1;
      for (t = 0; t < LIM && bus.snd_req; t++) @(negedge i_clk);
      bus.snd_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge i_clk);
    n_chk++;
    if ({bus.ready, bus.rcv_ack, bus.snd_req, bus.snd_pakio, bus.snd_idx} !== '0)
      $display("FAIL reset_outputs: ready=%b ack=%b req=%b pak=%h idx=%0d required all 0",
               bus.ready, bus.rcv_ack, bus.snd_req, bus.snd_pakio, bus.snd_idx);
    else n_pass++;
    reset = 1'b0;
    for (int t = 0; t < 20 && !bus.ready; t++) @(negedge i_clk);
    n_chk++;
    if (bus.ready !== 1'b1) $display("FAIL reset_ready: ready=%b required 1", bus.ready);
    else n_pass++;
  endtask

  task automatic test_single();
    int base;
    base = ack_rise[0];
    expect_msg(MSZ'(14'h2A5C));
    fork
      send_msg(0, MSZ'(14'h2A5C));
      recv_pkts(TOT_PKS);
    join
    repeat (10) @(negedge i_clk);
    n_chk++;
    if (ack_rise[0] - base !== 1) $display("FAIL single_ack_pulses: got %0d required 1", ack_rise[0] - base);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [MSZ-1:0] a, b;
    // ch1 alone leaves ptr at 0
    a = MSZ'($urandom);
    expect_msg(a);
    fork send_msg(1, a); recv_pkts(TOT_PKS); join
    a = MSZ'($urandom); b = MSZ'($urandom);
    expect_msg(a); expect_msg(b);
    fork send_msg(0, a); send_msg(1, b); recv_pkts(2 * TOT_PKS); join
    // ptr back to 0; ch0 alone moves it to 1, so ch1 wins next
    a = MSZ'($urandom);
    expect_msg(a);
    fork send_msg(0, a); recv_pkts(TOT_PKS); join
    a = MSZ'($urandom); b = MSZ'($urandom);
    expect_msg(b); expect_msg(a);
    fork send_msg(0, a); send_msg(1, b); recv_pkts(2 * TOT_PKS); join
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL contention_leftover: %0d packets required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [MSZ-1:0] m [5];
    for (int i = 0; i < 5; i++) begin
      m[i] = MSZ'($urandom);
      expect_msg(m[i]);
    end
    pkts_rcvd = 0;
    for (int i = 0; i < 4; i++) send_msg(0, m[i]);
    bus.rcv_msg[0] = m[4];
    bus.rcv_req[0] = 1'b1;
    repeat (30) @(negedge i_clk);
    n_chk++;
    if (bus.rcv_ack[0] !== 1'b0) $display("FAIL fill_ack_blocked: rcv_ack=%b required 0", bus.rcv_ack[0]);
    else n_pass++;
    fork
      begin
        int t;
        for (t = 0; t < LIM && !bus.rcv_ack[0]; t++) @(negedge i_clk);
        n_chk++;
        if (bus.rcv_ack[0] !== 1'b1) $display("FAIL fill_ack_late: rcv_ack=%b required 1", bus.rcv_ack[0]);
        else n_pass++;
        n_chk++;
        if (pkts_rcvd < TOT_PKS)
          $display("FAIL fill_ack_order: packets seen %0d required >= %0d", pkts_rcvd, TOT_PKS);
        else n_pass++;
        bus.rcv_req[0] = 1'b0;
        for (t = 0; t < LIM && bus.rcv_ack[0]; t++) @(negedge i_clk);
      end
      recv_pkts(5 * TOT_PKS);
    join
  endtask

  task automatic test_glitch();
    int base;
    logic [MSZ-1:0] a;
    base = ack_rise[1];
    bus.rcv_req[1] = 1'b1;
    repeat (REQ_CKS - 1) @(negedge i_clk);
    bus.rcv_req[1] = 1'b0;
    repeat (20) @(negedge i_clk);
    n_chk++;
    if (ack_rise[1] != base || bus.snd_req !== 1'b0)
      $display("FAIL glitch_req: ack pulses %0d snd_req=%b required 0 and 0", ack_rise[1] - base, bus.snd_req);
    else n_pass++;
    a = MSZ'($urandom);
    expect_msg(a);
    send_msg(0, a);
    for (int t = 0; t < LIM && !bus.snd_req; t++) @(negedge i_clk);
    bus.snd_ack = 1'b1;
    repeat (ACK_CKS - 1) @(negedge i_clk);
    bus.snd_ack = 1'b0;
    repeat (10) @(negedge i_clk);
    n_chk++;
    if (bus.snd_req !== 1'b1 || bus.snd_idx !== '0)
      $display("FAIL glitch_ack: snd_req=%b idx=%0d required 1 and 0", bus.snd_req, bus.snd_idx);
    else n_pass++;
    recv_pkts(TOT_PKS);
  endtask

  task automatic test_reset_mid();
    logic [MSZ-1:0] a;
    a = MSZ'($urandom);
    expect_msg(a);
    send_msg(0, a);
    send_msg(1, MSZ'($urandom));
    recv_pkts(2);
    for (int t = 0; t < LIM && !bus.snd_req; t++) @(negedge i_clk);
    n_chk++;
    if (bus.snd_idx !== IW'(2)) $display("FAIL rstmid_idx: snd_idx=%0d required 2", bus.snd_idx);
    else n_pass++;
    reset = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if ({bus.ready, bus.rcv_ack, bus.snd_req, bus.snd_pakio, bus.snd_idx} !== '0)
      $display("FAIL rstmid_outputs: ready=%b ack=%b req=%b pak=%h idx=%0d required all 0",
               bus.ready, bus.rcv_ack, bus.snd_req, bus.snd_pakio, bus.snd_idx);
    else n_pass++;
    reset = 1'b0;
    exp_q.delete();
    for (int t = 0; t < 20 && !bus.ready; t++) @(negedge i_clk);
    n_chk++;
    if (bus.ready !== 1'b1) $display("FAIL rstmid_ready: ready=%b required 1", bus.ready);
    else n_pass++;
    repeat (20) @(negedge i_clk);
    n_chk++;
    if (bus.snd_req !== 1'b0) $display("FAIL rstmid_fifo_empty: snd_req=%b required 0", bus.snd_req);
    else n_pass++;
    a = MSZ'($urandom);
    expect_msg(a);
    fork send_msg(1, a); recv_pkts(TOT_PKS); join
  endtask

  initial begin
    bus.rcv_req = '0;
    bus.rcv_msg = '0;
    bus.snd_ack = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_single();
    test_contention();
    test_fill();
    test_glitch();
    test_reset_mid();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL final_scoreboard: %0d packets left required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
